inst_link_fabric: RTL and testbench

INST_LINK_FABRIC -- requirements
Module: inst_link_fabric

---
 rtl/link_pkg.sv | 5 +
 rtl/link_fifo.sv | 39 +++
 rtl/inst_link_fabric.sv | 76 +++++++
 tb/tb_inst_link_fabric.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// link_pkg: channel mode encoding and stat counter width shared by the link fabric.
package link_pkg;
  localparam int STAT_W = 16;
  typedef enum logic [1:0] {PASS = 2'b00, TIE0 = 2'b01, TIE1 = 2'b10, OFF = 2'b11} link_mode_e;
endpackage

// File: rtl/link_fifo.sv
// link_fifo: per-channel buffer; extra pointer bit separates full from empty, flush wins over push/pop.
module link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rd_q[AW-1:0]];
  always_comb begin
    wr_d = flush ? '0 : do_push ? wr_q + 1'b1 : wr_q;
    rd_d = flush ? '0 : do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/inst_link_fabric.sv
// inst_link_fabric: NUM_CH independent source-slice-to-destination links with per-channel mode.
// Define LINK_STATS_EN to build the saturating per-channel pop counters; otherwise stat_cnt is tied to 0.
module inst_link_fabric
  import link_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int SLICE_W    = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int LW = DATA_W > 1 ? $clog2(DATA_W) : 1
) (
  input  logic                      main_clk,
  input  logic                      main_reset,
  input  logic                      cfg_wr,
  input  logic [CW-1:0]             cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [LW-1:0]             cfg_lsb,
  output logic                      cfg_err,
  input  logic [NUM_CH*DATA_W-1:0]  src_data,
  input  logic [NUM_CH-1:0]         src_valid,
  output logic [NUM_CH-1:0]         src_ready,
  output logic [NUM_CH*SLICE_W-1:0] dst_data,
  output logic [NUM_CH-1:0]         dst_valid,
  input  logic [NUM_CH-1:0]         dst_ready,
  output logic [NUM_CH*STAT_W-1:0]  stat_cnt
);
  logic cfg_bad, err_q;
  assign cfg_bad = 32'(cfg_ch) >= NUM_CH || 32'(cfg_lsb) > DATA_W - SLICE_W;
  assign cfg_err = err_q;
  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) err_q <= 1'b0;
    else err_q <= cfg_wr && cfg_bad;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    link_mode_e mode_q;
    logic [LW-1:0] lsb_q;
    logic hit, pass, push, pop, full, empty;
    logic [DATA_W-1:0] word;
    logic [SLICE_W-1:0] slice, head;
    assign hit = cfg_wr && !cfg_bad && cfg_ch == CW'(c);
    assign pass = mode_q == PASS;
    assign word = src_data[c*DATA_W +: DATA_W];
    assign slice = SLICE_W'(word >> lsb_q);
    // A channel being reconfigured drops its traffic for that cycle; the flush empties the buffer.
    assign push = pass && src_valid[c] && !hit;
    assign pop = pass && dst_ready[c] && !hit;
    assign src_ready[c] = pass ? !full : mode_q != OFF;
    assign dst_valid[c] = pass ? !empty : mode_q != OFF;
    assign dst_data[c*SLICE_W +: SLICE_W] = pass && !empty ? head : mode_q == TIE1 ? '1 : '0;
    link_fifo #(.WIDTH(SLICE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(main_clk), .rst(main_reset), .push(push), .pop(pop), .flush(hit),
      .din(slice), .dout(head), .full(full), .empty(empty)
    );
    always_ff @(posedge main_clk or posedge main_reset) begin
      if (main_reset) begin
        mode_q <= PASS;
        lsb_q <= '0;
      end else if (hit) begin
        mode_q <= link_mode_e'(cfg_mode);
        lsb_q <= cfg_lsb;
      end
    end
`ifdef LINK_STATS_EN
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge main_clk or posedge main_reset) begin
      if (main_reset) cnt_q <= '0;
      else if (hit) cnt_q <= '0;
      else if (pop && !empty && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign stat_cnt[c*STAT_W +: STAT_W] = cnt_q;
`else
    assign stat_cnt[c*STAT_W +: STAT_W] = '0;
`endif
  end
endmodule

// File: tb/tb_inst_link_fabric.sv
// tb_inst_link_fabric: scoreboard bench for the default 2-channel build, with or without LINK_STATS_EN.
module tb_inst_link_fabric;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [0:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_lsb = '0;
  logic        cfg_err;
  logic [31:0] src_data = '0;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_ready;
  logic [15:0] dst_data;
  logic [1:0]  dst_valid;
  logic [1:0]  dst_ready = '0;
  logic [31:0] stat_cnt;
  int n_chk = 0;
  int n_err = 0;
  int pcnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] q[$];

  inst_link_fabric dut (
    .main_clk(clk), .main_reset(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_lsb(cfg_lsb), .cfg_err(cfg_err), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
    .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int v);
`ifdef LINK_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int mode, input int lsb);
    cfg_wr = 1'b1;
    cfg_ch = 1'(ch);
    cfg_mode = 2'(mode);
    cfg_lsb = 4'(lsb);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic drain();
    dst_ready[0] = 1'b1;
    for (int i = 0; i < 30 && q.size() != 0; i++) tick();
    chk("drain_done", q.size(), 0);
  endtask

  // ch0 reference model: occupancy-based FIFO at lsb=8, checked every cycle it is enabled.
  always @(negedge clk) begin
    bit hit0, do_pop, do_push;
    if (rst) begin
      q.delete();
      pcnt = 0;
    end else begin
      hit0 = cfg_wr && cfg_ch == 1'b0 && cfg_lsb <= 4'd8;
      if (hit0) begin
        q.delete();
        pcnt = 0;
      end else if (mon_en) begin
        chk("ch0_valid", dst_valid[0], q.size() != 0);
        chk("ch0_ready", src_ready[0], q.size() < 4);
        if (q.size() != 0) chk("ch0_data", dst_data[7:0], q[0]);
        do_pop = dst_ready[0] && q.size() != 0;
        do_push = src_valid[0] && q.size() < 4;
        if (do_pop) begin
          void'(q.pop_front());
          pcnt++;
        end
        if (do_push) q.push_back(src_data[15:8]);
      end
    end
  end

  initial begin
    #1;
    chk("rst_dvalid", dst_valid, 2'b00);
    chk("rst_ddata", dst_data, 16'h0);
    chk("rst_sready", src_ready, 2'b11);
    chk("rst_cfgerr", cfg_err, 1'b0);
    chk("rst_stat", stat_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_dvalid", dst_valid, 2'b00);
    chk("rel_ddata", dst_data, 16'h0);
    chk("rel_sready", src_ready, 2'b11);
    chk("rel_cfgerr", cfg_err, 1'b0);
    tick();
    cfg(0, 0, 8);
    mon_en = 1'b1;
    @(negedge clk);
    chk("good_cfg_err", cfg_err, 1'b0);
    tick();
    src_data[15:0] = 16'hA55A;
    src_valid[0] = 1'b1;
    dst_ready[0] = 1'b1;
    tick();
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("a5_valid", dst_valid[0], 1'b1);
    chk("a5_data", dst_data[7:0], 8'hA5);
    tick();
    dst_ready[0] = 1'b0;
    src_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_data[15:0] = 16'(16'h1100 * (i + 1) + i);
      tick();
    end
    @(negedge clk);
    chk("bp_full_ready", src_ready[0], 1'b0);
    chk("bp_full_valid", dst_valid[0], 1'b1);
    tick();
    src_valid[0] = 1'b0;
    drain();
    chk("bp_pops", pcnt, 5);
    dst_ready[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("stat_after_bp", stat_cnt[15:0], exp_stat(5));
    chk("stat_ch1_idle", stat_cnt[31:16], 32'h0);
    tick();
    src_data[15:0] = 16'h7788;
    src_valid[0] = 1'b1;
    cfg(1, 2, 0);
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("tie1_data", dst_data[15:8], 8'hFF);
    chk("tie1_valid", dst_valid[1], 1'b1);
    chk("tie1_ready", src_ready[1], 1'b1);
    chk("tie1_ch0_valid", dst_valid[0], 1'b1);
    chk("tie1_ch0_data", dst_data[7:0], 8'h77);
    tick();
    drain();
    cfg(1, 1, 0);
    @(negedge clk);
    chk("tie0_data", dst_data[15:8], 8'h00);
    chk("tie0_valid", dst_valid[1], 1'b1);
    tick();
    cfg(1, 3, 0);
    @(negedge clk);
    chk("off_valid", dst_valid[1], 1'b0);
    chk("off_ready", src_ready[1], 1'b0);
    chk("off_data", dst_data[15:8], 8'h00);
    tick();
    cfg_wr = 1'b1;
    cfg_ch = 1'b0;
    cfg_mode = 2'b01;
    cfg_lsb = 4'd12;
    @(negedge clk);
    chk("bad_err_same", cfg_err, 1'b0);
    tick();
    cfg_wr = 1'b0;
    @(negedge clk);
    chk("bad_err_pulse", cfg_err, 1'b1);
    tick();
    @(negedge clk);
    chk("bad_err_end", cfg_err, 1'b0);
    tick();
    dst_ready[0] = 1'b0;
    src_data[15:0] = 16'hC33C;
    src_valid[0] = 1'b1;
    tick();
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("bad_keep_data", dst_data[7:0], 8'hC3);
    tick();
    drain();
    cfg(0, 0, 8);
    src_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src_data[15:0] = 16'(16'h0100 * (i * 7 + 3));
      tick();
    end
    src_valid[0] = 1'b0;
    drain();
    dst_ready[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("stat_ten", stat_cnt[15:0], exp_stat(10));
    tick();
    cfg(0, 0, 8);
    @(negedge clk);
    chk("stat_clear", stat_cnt[15:0], 32'h0);
    tick();
    src_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data[15:0] = 16'(16'h2200 * (i + 1));
      tick();
    end
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", dst_valid[0], 1'b1);
    @(posedge clk);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_dvalid", dst_valid, 2'b00);
    chk("async_ddata", dst_data, 16'h0);
    chk("async_stat", stat_cnt, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dvalid", dst_valid, 2'b00);
    chk("post_rst_sready", src_ready, 2'b11);
    chk("post_rst_stat", stat_cnt, 32'h0);
    tick();
    cfg(0, 0, 8);
    mon_en = 1'b1;
    src_data[15:0] = 16'h5A00;
    src_valid[0] = 1'b1;
    tick();
    src_valid[0] = 1'b0;
    drain();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
